// File: rtl/pkt_rx_pkg.sv
// Shared definitions for the packet ingress checker: header field layout,
// FSM state encoding and the descriptor record.
package pkt_rx_pkg;
    localparam int DA_LSB    = 0;
    localparam int DA_W      = 4;
    localparam int PRIOR_LSB = 4;
    localparam int PRIOR_W   = 3;
    localparam int LEN_LSB   = 7;
    localparam int LEN_W     = 10;
    localparam int DESC_W    = DA_W + PRIOR_W + LEN_W;
    localparam int BEATS_W   = 11;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RECV = 2'd1,
        ST_DROP = 2'd2
    } state_t;

    typedef struct packed {
        logic [DA_W-1:0]    da;
        logic [PRIOR_W-1:0] prior;
        logic [LEN_W-1:0]   len;
    } desc_t;
endpackage

// File: rtl/pkt_rx_desc_fifo.sv
// First-word-fall-through descriptor queue; the head entry is visible
// combinationally and reads as zero while the queue is empty.
module pkt_rx_desc_fifo
    import pkt_rx_pkg::*;
#(
    parameter int AW = 3
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              push,
    input  logic [DESC_W-1:0] din,
    input  logic              pop,
    output logic [DESC_W-1:0] dout,
    output logic              full,
    output logic              empty
);
    logic [DESC_W-1:0] mem [2**AW];
    logic [AW:0]       wr_ptr;
    logic [AW:0]       rd_ptr;

    assign empty = (wr_ptr == rd_ptr);
    assign full  = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign dout  = empty ? '0 : mem[rd_ptr[AW-1:0]];

    always_ff @(posedge clk) begin
        if (push && !full) begin
            mem[wr_ptr[AW-1:0]] <= din;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (push && !full) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (pop && !empty) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
        end
    end
endmodule

// File: rtl/pkt_rx_check.sv
// Packet ingress checker: parses headers, buffers payload speculatively,
// commits framed packets with a descriptor and counts discards.
module pkt_rx_check
    import pkt_rx_pkg::*;
#(
    parameter int DW          = 32,
    parameter int PL_ADDR_W   = 9,
    parameter int DESC_ADDR_W = 3
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          i_sop,
    input  logic          i_vld,
    input  logic [DW-1:0] i_data,
    input  logic          i_eop,
    output logic          o_desc_vld,
    output logic [3:0]    o_desc_da,
    output logic [2:0]    o_desc_prior,
    output logic [9:0]    o_desc_len,
    input  logic          i_desc_ready,
    output logic          o_pl_vld,
    output logic [DW-1:0] o_pl_data,
    input  logic          i_pl_rden,
    output logic [15:0]   o_drop_cnt,
    output logic [15:0]   o_err_cnt
);
    localparam int BYTE_SH = $clog2(DW / 8);
    localparam int PW      = PL_ADDR_W + 1;
    localparam int SW      = (PW + 1 > BEATS_W) ? PW + 1 : BEATS_W;

    function automatic logic [15:0] sat_add(input logic [15:0] a, input logic [1:0] inc);
        logic [16:0] s;
        s = {1'b0, a} + {15'd0, inc};
        return s[16] ? 16'hFFFF : s[15:0];
    endfunction

    state_t             state, state_nxt;
    logic [PW-1:0]      spec_wr, spec_wr_nxt, commit_wr, commit_wr_nxt, rd_ptr, used;
    logic [BEATS_W-1:0] beat_cnt, beat_cnt_nxt, beats, cnt_inc, in_beats, len_ext;
    desc_t              hdr, in_hdr, desc_out;
    logic [1:0]         err_inc;
    logic               drop_inc, push, wr_en, hdr_eval, hdr_load, space_ok;
    logic               desc_full, desc_empty, pl_load;
    logic [DW-1:0]      pl_mem [2**PL_ADDR_W];

    assign in_hdr   = {i_data[DA_LSB +: DA_W], i_data[PRIOR_LSB +: PRIOR_W], i_data[LEN_LSB +: LEN_W]};
    assign len_ext  = {1'b0, in_hdr.len};
    assign in_beats = (len_ext + BEATS_W'(DW / 8 - 1)) >> BYTE_SH;
    // Only one packet is ever in flight, so registered pointers give a safe free count.
    assign used     = commit_wr - rd_ptr;
    assign space_ok = (SW'(in_beats) <= SW'(2 ** PL_ADDR_W) - SW'(used)) && !desc_full;

    always_comb begin
        state_nxt     = state;
        spec_wr_nxt   = spec_wr;
        commit_wr_nxt = commit_wr;
        beat_cnt_nxt  = beat_cnt;
        err_inc       = 2'd0;
        drop_inc      = 1'b0;
        push          = 1'b0;
        wr_en         = 1'b0;
        hdr_eval      = 1'b0;
        hdr_load      = 1'b0;
        cnt_inc       = beat_cnt + 1'b1;
        if (i_vld) begin
            unique case (state)
                ST_IDLE: hdr_eval = i_sop;
                ST_RECV: begin
                    if (i_sop) begin
                        spec_wr_nxt = commit_wr;
                        err_inc     = 2'd1;
                        hdr_eval    = 1'b1;
                    end else begin
                        wr_en        = 1'b1;
                        spec_wr_nxt  = spec_wr + 1'b1;
                        beat_cnt_nxt = cnt_inc;
                        if (i_eop && cnt_inc == beats) begin
                            commit_wr_nxt = spec_wr + 1'b1;
                            push          = 1'b1;
                            state_nxt     = ST_IDLE;
                        end else if (i_eop || cnt_inc == beats) begin
                            spec_wr_nxt = commit_wr;
                            err_inc     = 2'd1;
                            state_nxt   = i_eop ? ST_IDLE : ST_DROP;
                        end
                    end
                end
                ST_DROP: begin
                    if (i_sop) begin
                        hdr_eval = 1'b1;
                    end else if (i_eop) begin
                        state_nxt = ST_IDLE;
                    end
                end
                default: state_nxt = ST_IDLE;
            endcase
            if (hdr_eval) begin
                if (i_eop) begin
                    err_inc   = err_inc + 2'd1;
                    state_nxt = ST_IDLE;
                end else if (in_hdr.len == '0) begin
                    err_inc   = err_inc + 2'd1;
                    state_nxt = ST_DROP;
                end else if (space_ok) begin
                    state_nxt    = ST_RECV;
                    beat_cnt_nxt = '0;
                    spec_wr_nxt  = commit_wr;
                    hdr_load     = 1'b1;
                end else begin
                    drop_inc  = 1'b1;
                    state_nxt = ST_DROP;
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= ST_IDLE;
            spec_wr    <= '0;
            commit_wr  <= '0;
            beat_cnt   <= '0;
            beats      <= '0;
            o_err_cnt  <= '0;
            o_drop_cnt <= '0;
        end else begin
            state      <= state_nxt;
            spec_wr    <= spec_wr_nxt;
            commit_wr  <= commit_wr_nxt;
            beat_cnt   <= beat_cnt_nxt;
            o_err_cnt  <= sat_add(o_err_cnt, err_inc);
            o_drop_cnt <= sat_add(o_drop_cnt, {1'b0, drop_inc});
            if (hdr_load) begin
                beats <= in_beats;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (hdr_load) begin
            hdr <= in_hdr;
        end
        if (wr_en) begin
            pl_mem[spec_wr[PL_ADDR_W-1:0]] <= i_data;
        end
    end

    // Output register prefetches the next committed word so the reader sees FWFT data.
    assign pl_load = (commit_wr != rd_ptr) && (!o_pl_vld || i_pl_rden);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_ptr    <= '0;
            o_pl_vld  <= 1'b0;
            o_pl_data <= '0;
        end else if (pl_load) begin
            rd_ptr    <= rd_ptr + 1'b1;
            o_pl_data <= pl_mem[rd_ptr[PL_ADDR_W-1:0]];
            o_pl_vld  <= 1'b1;
        end else if (i_pl_rden) begin
            o_pl_vld <= 1'b0;
        end
    end

    pkt_rx_desc_fifo #(
        .AW(DESC_ADDR_W)
    ) u_desc_fifo (
        .clk   (clk),
        .rst_n (rst_n),
        .push  (push),
        .din   (hdr),
        .pop   (i_desc_ready),
        .dout  (desc_out),
        .full  (desc_full),
        .empty (desc_empty)
    );

    assign o_desc_vld   = !desc_empty;
    assign o_desc_da    = desc_out.da;
    assign o_desc_prior = desc_out.prior;
    assign o_desc_len   = desc_out.len;
endmodule

// File: tb/tb_pkt_rx_check.sv
// Scoreboard bench for pkt_rx_check: directed scenarios plus randomized
// packet streams, with expected descriptors/words queued at stimulus time.
module tb_pkt_rx_check;
    localparam int DW    = 32;
    localparam int BYTES = DW / 8;

    logic          clk = 1'b0;
    logic          rst_n = 1'b1;
    logic          i_sop = 1'b0, i_vld = 1'b0, i_eop = 1'b0;
    logic [DW-1:0] i_data = '0;
    logic          desc_ready = 1'b0, pl_rden = 1'b0;
    logic          o_desc_vld, o_pl_vld;
    logic [3:0]    o_desc_da;
    logic [2:0]    o_desc_prior;
    logic [9:0]    o_desc_len;
    logic [DW-1:0] o_pl_data;
    logic [15:0]   o_drop_cnt, o_err_cnt;

    logic [16:0]   exp_desc[$];
    logic [DW-1:0] exp_pl[$];
    int n_cmp = 0, n_fail = 0, exp_err = 0, exp_drop = 0;
    int pl_budget = -1;
    bit desc_mode = 1'b0, pl_mode = 1'b0, gaps = 1'b0;

    pkt_rx_check #(.DW(DW), .PL_ADDR_W(4), .DESC_ADDR_W(3)) dut (
        .clk(clk), .rst_n(rst_n), .i_sop(i_sop), .i_vld(i_vld), .i_data(i_data), .i_eop(i_eop),
        .o_desc_vld(o_desc_vld), .o_desc_da(o_desc_da), .o_desc_prior(o_desc_prior),
        .o_desc_len(o_desc_len), .i_desc_ready(desc_ready), .o_pl_vld(o_pl_vld),
        .o_pl_data(o_pl_data), .i_pl_rden(pl_rden), .o_drop_cnt(o_drop_cnt), .o_err_cnt(o_err_cnt)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic fail_now(input string name);
        n_cmp++;
        n_fail++;
        $display("FAIL %s", name);
    endtask

    function automatic logic [31:0] sat(input int v);
        return (v > 65535) ? 32'd65535 : 32'(v);
    endfunction

    function automatic int nbeats(input int len);
        return (len + BYTES - 1) / BYTES;
    endfunction

    // Monitor: chooses ready/rden for the coming edge, then scores any pop it causes.
    always @(negedge clk) begin
        if (!rst_n) begin
            desc_ready = 1'b0;
            pl_rden    = 1'b0;
        end else begin
            desc_ready = desc_mode;
            pl_rden    = pl_mode && (pl_budget != 0);
            if (desc_ready && o_desc_vld) begin
                if (exp_desc.size() == 0) fail_now("desc_unexpected");
                else check("desc", 32'({o_desc_da, o_desc_prior, o_desc_len}), 32'(exp_desc.pop_front()));
            end
            if (pl_rden && o_pl_vld) begin
                if (exp_pl.size() == 0) fail_now("pl_unexpected");
                else check("pl_word", o_pl_data, exp_pl.pop_front());
                if (pl_budget > 0) pl_budget--;
            end
        end
    end

    task automatic beat(input logic s, input logic v, input logic [DW-1:0] d, input logic e);
        @(posedge clk);
        #1;
        i_sop  = s;
        i_vld  = v;
        i_data = d;
        i_eop  = e;
    endtask

    task automatic idle(input int n);
        repeat (n) beat(1'b0, 1'b0, '0, 1'b0);
    endtask

    task automatic bubble();
        if (gaps && $urandom_range(0, 3) == 0)
            beat(1'($urandom_range(0, 1)), 1'b0, DW'($urandom()), 1'($urandom_range(0, 1)));
    endtask

    task automatic send_hdr(input logic [3:0] da, input logic [2:0] pr, input logic [9:0] len, input logic e);
        logic [DW-1:0] d;
        d = DW'($urandom());
        d[16:0] = {len, pr, da};
        beat(1'b1, 1'b1, d, e);
    endtask

    task automatic send_body(input int n, input bit eop_last);
        for (int b = 1; b <= n; b++) begin
            bubble();
            beat(1'b0, 1'b1, DW'($urandom()), eop_last && (b == n));
        end
    endtask

    task automatic send_good(input logic [3:0] da, input logic [2:0] pr, input logic [9:0] len, input bit keep);
        logic [DW-1:0] w;
        int nb;
        nb = nbeats(int'(len));
        send_hdr(da, pr, len, 1'b0);
        for (int b = 1; b <= nb; b++) begin
            bubble();
            w = DW'($urandom());
            if (keep) exp_pl.push_back(w);
            beat(1'b0, 1'b1, w, b == nb);
        end
        if (keep) exp_desc.push_back({da, pr, len});
    endtask

    task automatic send_rand_good();
        send_good(4'($urandom()), 3'($urandom()), 10'($urandom_range(1, 16)), 1'b1);
    endtask

    task automatic wait_drain(input string name);
        int n;
        n = 0;
        while ((exp_desc.size() != 0 || exp_pl.size() != 0 || o_pl_vld || o_desc_vld) && n < 3000) begin
            @(posedge clk);
            n++;
        end
        if (n >= 3000) fail_now({name, "_drain_timeout"});
    endtask

    task automatic check_counts(input string name);
        check({name, "_err_cnt"}, 32'(o_err_cnt), sat(exp_err));
        check({name, "_drop_cnt"}, 32'(o_drop_cnt), sat(exp_drop));
    endtask

    task automatic check_reset_outputs(input string name);
        check({name, "_desc_vld"}, 32'(o_desc_vld), 32'd0);
        check({name, "_desc"}, 32'({o_desc_da, o_desc_prior, o_desc_len}), 32'd0);
        check({name, "_pl_vld"}, 32'(o_pl_vld), 32'd0);
        check({name, "_pl_data"}, o_pl_data, 32'd0);
        check({name, "_err_cnt"}, 32'(o_err_cnt), 32'd0);
        check({name, "_drop_cnt"}, 32'(o_drop_cnt), 32'd0);
    endtask

    initial begin
        #1000000;
        $display("FAIL global_timeout");
        $fatal(1, "simulation did not finish");
    end

    initial begin
        int len, nb, n;
        #2 rst_n = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check_reset_outputs("reset");
        @(negedge clk);
        rst_n = 1'b1;
        desc_mode = 1'b1;
        pl_mode = 1'b1;

        // Single 10-byte packet.
        send_good(4'd5, 3'd3, 10'd10, 1'b1);
        idle(2);
        wait_drain("single");
        check_counts("single");

        // Early eop on beat 2 of a 16-byte packet, reader stalled.
        desc_mode = 1'b0;
        pl_mode = 1'b0;
        send_hdr(4'd1, 3'd2, 10'd16, 1'b0);
        send_body(2, 1'b1);
        exp_err++;
        idle(4);
        check("early_pl_vld", 32'(o_pl_vld), 32'd0);
        check("early_desc_vld", 32'(o_desc_vld), 32'd0);
        check_counts("early");
        desc_mode = 1'b1;
        pl_mode = 1'b1;
        send_good(4'd9, 3'd1, 10'd12, 1'b1);
        idle(2);
        wait_drain("after_early");

        // New header on beat 2 of a 5-beat packet.
        send_hdr(4'd2, 3'd4, 10'd20, 1'b0);
        send_body(1, 1'b0);
        exp_err++;
        send_good(4'd7, 3'd6, 10'd13, 1'b1);
        idle(2);
        wait_drain("sop_mid");
        check_counts("sop_mid");

        // Randomized mix of good and malformed packets.
        gaps = 1'b1;
        for (int p = 0; p < 80; p++) begin
            case ($urandom_range(0, 9))
                0, 1, 2, 3: send_rand_good();
                4: begin
                    len = $urandom_range(5, 16);
                    send_hdr(4'($urandom()), 3'($urandom()), 10'(len), 1'b0);
                    send_body($urandom_range(1, nbeats(len) - 1), 1'b1);
                    exp_err++;
                end
                5: begin
                    len = $urandom_range(1, 16);
                    send_hdr(4'($urandom()), 3'($urandom()), 10'(len), 1'b0);
                    send_body(nbeats(len), 1'b0);
                    send_body($urandom_range(1, 3), 1'b1);
                    exp_err++;
                end
                6: begin
                    len = $urandom_range(5, 16);
                    send_hdr(4'($urandom()), 3'($urandom()), 10'(len), 1'b0);
                    send_body($urandom_range(0, nbeats(len) - 1), 1'b0);
                    exp_err++;
                    send_rand_good();
                end
                7: begin
                    send_hdr(4'($urandom()), 3'($urandom()), 10'd0, 1'b0);
                    send_body($urandom_range(1, 3), 1'b1);
                    exp_err++;
                end
                8: begin
                    send_hdr(4'($urandom()), 3'($urandom()), 10'($urandom()), 1'b1);
                    exp_err++;
                end
                default: beat(1'b0, 1'b1, DW'($urandom()), 1'($urandom_range(0, 1)));
            endcase
            if ($urandom_range(0, 3) == 0) idle($urandom_range(1, 3));
        end
        gaps = 1'b0;
        idle(2);
        wait_drain("random");
        check_counts("random");

        // Buffer exhaustion with a 16-word buffer and 8-beat packets.
        desc_mode = 1'b0;
        pl_mode = 1'b0;
        send_good(4'd3, 3'd0, 10'd32, 1'b1);
        send_good(4'd4, 3'd1, 10'd32, 1'b1);
        send_good(4'd6, 3'd2, 10'd32, 1'b0);
        exp_drop++;
        idle(3);
        check_counts("exhaust");
        pl_budget = 8;
        pl_mode = 1'b1;
        n = 0;
        while (pl_budget != 0 && n < 200) begin
            @(posedge clk);
            n++;
        end
        if (n >= 200) fail_now("exhaust_read_timeout");
        pl_mode = 1'b0;
        idle(2);
        send_good(4'd8, 3'd5, 10'd32, 1'b1);
        idle(3);
        check_counts("exhaust_refill");
        pl_budget = -1;
        pl_mode = 1'b1;
        desc_mode = 1'b1;
        wait_drain("exhaust");

        // Descriptor queue full, then forced drop-counter saturation.
        desc_mode = 1'b0;
        for (int p = 0; p < 8; p++) send_good(4'(p), 3'(p), 10'd4, 1'b1);
        send_good(4'd15, 3'd7, 10'd4, 1'b0);
        exp_drop++;
        idle(2);
        check_counts("desc_full");
        for (int i = 0; i < 65536; i++) send_hdr(4'd1, 3'd1, 10'd4, 1'b0);
        exp_drop += 65536;
        idle(2);
        check_counts("saturate");
        desc_mode = 1'b1;
        wait_drain("desc_full");

        // Asynchronous reset in the middle of a packet.
        desc_mode = 1'b0;
        pl_mode = 1'b0;
        send_good(4'd12, 3'd2, 10'd8, 1'b1);
        idle(5);
        send_hdr(4'd10, 3'd3, 10'd20, 1'b0);
        send_body(2, 1'b0);
        @(negedge clk);
        #1;
        rst_n = 1'b0;
        i_vld = 1'b0;
        i_sop = 1'b0;
        i_eop = 1'b0;
        #1;
        check_reset_outputs("async_reset");
        exp_desc.delete();
        exp_pl.delete();
        exp_err = 0;
        exp_drop = 0;
        @(negedge clk);
        #1;
        rst_n = 1'b1;
        desc_mode = 1'b1;
        pl_mode = 1'b1;
        send_good(4'd11, 3'd4, 10'd9, 1'b1);
        idle(2);
        wait_drain("post_reset");
        check_counts("post_reset");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end
endmodule
